// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF   = 16;
  // wait counter is sized for the largest legal TIMEOUT (2^16-1)
  localparam int unsigned WAIT_W      = 16;

  // ST_RUN and ST_DWAIT are the only live codes besides ST_HALT; 2'b11 decodes as HALT
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DWAIT = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  // Reason the pipeline controls look the way they do this cycle (debug visibility)
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_BRANCH   = 3'd1,
    CAUSE_LOAD_USE = 3'd2,
    CAUSE_IMEM     = 3'd3,
    CAUSE_DMEM     = 3'd4,
    CAUSE_HALT     = 3'd5
  } cause_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctl_t;

  // Register-bank enables and bubble inserts for each stall cause
  function automatic ctl_t ctl_for_cause(input cause_e cause);
    ctl_t c;
    c = '0;
    case (cause)
      CAUSE_NONE:     c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                            mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
      CAUSE_BRANCH:   c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                            mem_wb_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
      CAUSE_LOAD_USE: c = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                            mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1};
      CAUSE_IMEM:     c = '{pc_en: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                            mem_wb_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Event inputs and pipeline-control outputs of the stall/flush sequencer.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             ld_use_haz;
  logic             br_taken_ex;
  logic             imem_rdy;
  logic             dmem_acc_mem;
  logic             dmem_rdy;
  logic             hlt_wb;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: raises hazard/handshake events, consumes the controls
  modport master (
    output ld_use_haz, br_taken_ex, imem_rdy, dmem_acc_mem, dmem_rdy, hlt_wb,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    input  halted, err_timeout, stall_cycles
  );

  // Sequencer side
  modport slave (
    input  ld_use_haz, br_taken_ex, imem_rdy, dmem_acc_mem, dmem_rdy, hlt_wb,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    output halted, err_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------------
//  ST_RUN   | normal flow; hazards/branches/fetch misses resolved same cycle
//  ST_DWAIT | data access outstanding, whole pipe frozen until dmem_rdy
//  ST_HALT  | stopped by HLT retirement or data-wait timeout; exit by reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_halted;
  logic               r_err_timeout;
  logic               w_halt_set;
  logic               w_err_set;
  logic               w_is_halt;
  logic               w_freeze;
  logic               w_timeout_hit;
  logic               w_wait_inc;
  logic               w_wait_clr;
  logic               w_stall_inc;
  logic [WAIT_W-1:0]  w_wait_cnt;
  logic [CNT_W-1:0]   w_stall_cnt;
  cause_e             w_cause;
  ctl_t               w_ctl_raw;
  ctl_t               w_ctl;

  assign w_is_halt     = (r_state != ST_RUN) && (r_state != ST_DWAIT);
  assign w_freeze      = !w_is_halt && bus.dmem_acc_mem && !bus.dmem_rdy;
  // this is the TIMEOUT-th consecutive frozen DWAIT cycle
  assign w_timeout_hit = (r_state == ST_DWAIT) && w_freeze &&
                         (w_wait_cnt == WAIT_W'(TIMEOUT - 1));

  assign w_wait_inc  = (r_state == ST_DWAIT) && w_freeze;
  assign w_wait_clr  = !w_wait_inc;
  // uses the ungated pc_en; the counter is held in reset anyway
  assign w_stall_inc = !w_is_halt && !w_ctl_raw.pc_en;

  // State register plus sticky halt/timeout flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_halted      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_halt_set) r_halted      <= 1'b1;
      if (w_err_set)  r_err_timeout <= 1'b1;
    end
  end

  // Next-state decode: freeze entry/exit, timeout, HLT retirement
  always_comb begin
    w_state_nxt = r_state;
    w_halt_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_freeze) begin
          w_state_nxt = ST_DWAIT;
        end else if (bus.hlt_wb) begin
          w_state_nxt = ST_HALT;
          w_halt_set  = 1'b1;
        end
      end
      ST_DWAIT: begin
        if (w_freeze) begin
          if (w_timeout_hit) begin
            w_state_nxt = ST_HALT;
            w_halt_set  = 1'b1;
            w_err_set   = 1'b1;
          end
        end else if (bus.hlt_wb) begin
          w_state_nxt = ST_HALT;
          w_halt_set  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  // Output decode: pick the winning cause, map it to enables/flushes, gate by reset
  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_is_halt) begin
      w_cause = CAUSE_HALT;
    end else if (w_freeze) begin
      w_cause = CAUSE_DMEM;
    end else if (bus.br_taken_ex) begin
      w_cause = CAUSE_BRANCH;
    end else if (bus.ld_use_haz) begin
      w_cause = CAUSE_LOAD_USE;
    end else if (!bus.imem_rdy) begin
      w_cause = CAUSE_IMEM;
    end
    w_ctl_raw = ctl_for_cause(w_cause);
    w_ctl     = rst_n ? w_ctl_raw : '0;
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wait_inc),
    .clr   (w_wait_clr),
    .cnt   (w_wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (1'b0),
    .cnt   (w_stall_cnt)
  );

  assign bus.pc_en        = w_ctl.pc_en;
  assign bus.if_id_en     = w_ctl.if_id_en;
  assign bus.id_ex_en     = w_ctl.id_ex_en;
  assign bus.ex_mem_en    = w_ctl.ex_mem_en;
  assign bus.mem_wb_en    = w_ctl.mem_wb_en;
  assign bus.if_id_flush  = w_ctl.if_id_flush;
  assign bus.id_ex_flush  = w_ctl.id_ex_flush;
  assign bus.halted       = r_halted;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.stall_cycles = w_stall_cnt;

endmodule
